// File: rtl/multicycle_ctrl_if.sv
// Handshake/strobe bundle between multicycle_ctrl (master) and datapath/memories (slave).
// Optional perf counter fields appear only when CTRL_PERF_EN is defined.
interface multicycle_ctrl_if
`ifdef CTRL_PERF_EN
  #(parameter int RETIRE_W = 32)
`endif
  ;
  logic [31:0] inst_code;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src_br;
  logic        alu_src_imm;
  logic [1:0]  alu_op;
  logic        mem_rd;
  logic        mem_wr;
  logic        reg_we;
  logic        mem_to_reg;
  logic        trap;
  logic        bus_err;
  logic [2:0]  state;
`ifdef CTRL_PERF_EN
  logic [RETIRE_W-1:0] retired;
  logic [15:0]         stall_cyc;
`endif

  modport master (
    input  inst_code, zero, imem_ready, dmem_ready,
    output imem_req, ir_we, pc_we, pc_src_br, alu_src_imm, alu_op,
           mem_rd, mem_wr, reg_we, mem_to_reg, trap, bus_err, state
`ifdef CTRL_PERF_EN
    , output retired, stall_cyc
`endif
  );

  modport slave (
    output inst_code, zero, imem_ready, dmem_ready,
    input  imem_req, ir_we, pc_we, pc_src_br, alu_src_imm, alu_op,
           mem_rd, mem_wr, reg_we, mem_to_reg, trap, bus_err, state
`ifdef CTRL_PERF_EN
    , input retired, stall_cyc
`endif
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I subset core with sticky trap state.
// Optional macro CTRL_PERF_EN adds retired-instruction and stall-cycle counters.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef CTRL_PERF_EN
  ,
  parameter int RETIRE_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  localparam int CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] waitCnt_q, waitCnt_d;
  logic            trap_q, trap_d;
  logic            busErr_q, busErr_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       isLoad, isStore, isAluI, isAluR, isBranch, legal;
  logic       unusedInstBits;

  assign opcode   = bus.inst_code[6:0];
  assign funct3   = bus.inst_code[14:12];
  assign isLoad   = (opcode == 7'b0000011);
  assign isStore  = (opcode == 7'b0100011);
  assign isAluI   = (opcode == 7'b0010011);
  assign isAluR   = (opcode == 7'b0110011);
  assign isBranch = (opcode == 7'b1100011);
  assign legal    = isLoad | isStore | isAluI | isAluR | (isBranch && (funct3[2:1] == 2'b00));
  assign unusedInstBits = ^{bus.inst_code[31:15], bus.inst_code[11:7]};

  logic       imemReq, irWe, pcWe, pcSrcBr, aluSrcImm, memRd, memWr, regWe, memToReg;
  logic [1:0] aluOp;

  always_comb begin
    imemReq   = 1'b0;
    irWe      = 1'b0;
    pcWe      = 1'b0;
    pcSrcBr   = 1'b0;
    aluSrcImm = 1'b0;
    aluOp     = 2'b00;
    memRd     = 1'b0;
    memWr     = 1'b0;
    regWe     = 1'b0;
    memToReg  = 1'b0;
    case (state_q)
      FETCH: begin
        imemReq = 1'b1;
        irWe    = bus.imem_ready;
      end
      EXEC: begin
        aluSrcImm = isAluI | isLoad | isStore;
        aluOp     = isBranch ? 2'b01 : ((isLoad | isStore) ? 2'b00 : 2'b10);
        // BNE (funct3[0]=1) inverts the sense of the ALU zero flag
        if (isBranch) begin
          pcWe    = 1'b1;
          pcSrcBr = bus.zero ^ funct3[0];
        end
      end
      MEM: begin
        memRd = isLoad;
        memWr = isStore;
        pcWe  = isStore & bus.dmem_ready;
      end
      WB: begin
        regWe    = 1'b1;
        memToReg = isLoad;
        pcWe     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    trap_d    = trap_q;
    busErr_d  = busErr_q;
    case (state_q)
      FETCH:  if (bus.imem_ready) state_d = DECODE;
      DECODE: begin
        state_d = legal ? EXEC : TRAP;
        trap_d  = trap_q | ~legal;
      end
      EXEC: begin
        waitCnt_d = '0;
        if (isBranch)              state_d = FETCH;
        else if (isLoad | isStore) state_d = MEM;
        else                       state_d = WB;
      end
      MEM: begin
        // a completion arriving in the final allowed cycle still beats the timeout
        if (bus.dmem_ready) begin
          state_d = isLoad ? WB : FETCH;
        end else if (waitCnt_q == CntLast) begin
          state_d  = TRAP;
          trap_d   = 1'b1;
          busErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      WB:   state_d = FETCH;
      TRAP: state_d = TRAP;
      default: begin
        state_d = TRAP;
        trap_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      waitCnt_q <= '0;
      trap_q    <= 1'b0;
      busErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      trap_q    <= trap_d;
      busErr_q  <= busErr_d;
    end
  end

  assign bus.imem_req    = imemReq;
  assign bus.ir_we       = irWe;
  assign bus.pc_we       = pcWe;
  assign bus.pc_src_br   = pcSrcBr;
  assign bus.alu_src_imm = aluSrcImm;
  assign bus.alu_op      = aluOp;
  assign bus.mem_rd      = memRd;
  assign bus.mem_wr      = memWr;
  assign bus.reg_we      = regWe;
  assign bus.mem_to_reg  = memToReg;
  assign bus.trap        = trap_q;
  assign bus.bus_err     = busErr_q;
  assign bus.state       = state_q;

`ifdef CTRL_PERF_EN
  logic [RETIRE_W-1:0] retired_q;
  logic [15:0]         stallCyc_q;
  logic                stallNow;

  assign stallNow = ((state_q == FETCH) && !bus.imem_ready) ||
                    ((state_q == MEM) && !bus.dmem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q  <= '0;
      stallCyc_q <= '0;
    end else begin
      if (pcWe) retired_q <= retired_q + RETIRE_W'(1);
      if (stallNow && (stallCyc_q != 16'hFFFF)) stallCyc_q <= stallCyc_q + 16'd1;
    end
  end

  assign bus.retired   = retired_q;
  assign bus.stall_cyc = stallCyc_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push expected retire/trap records,
// an independent monitor accumulates per-instruction strobe activity and compares on each event.
module tb_multicycle_ctrl;

  localparam int MemTimeout = 16;

  localparam logic [31:0] InstAddi   = 32'h00500093;
  localparam logic [31:0] InstAdd    = 32'h002081B3;
  localparam logic [31:0] InstBeq    = 32'h00208463;
  localparam logic [31:0] InstBne    = 32'h00209463;
  localparam logic [31:0] InstBadBr  = 32'h0020A463;
  localparam logic [31:0] InstLw     = 32'h0000A283;
  localparam logic [31:0] InstSw     = 32'h0050A223;
  localparam logic [31:0] InstJal    = 32'h0000006F;

  typedef struct {
    bit         isTrap;
    bit         busErr;
    bit         pcSrcBr;
    int         regWeCyc;
    bit         memToReg;
    int         memRdCyc;
    int         memWrCyc;
    int         irWeCyc;
    bit         aluSrcImm;
    logic [1:0] aluOp;
    int         latency;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   expRetired = 0;
  exp_t  expQ[$];
  string nameQ[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(MemTimeout)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  function automatic exp_t mkExp(bit isTrap, bit busErr, bit pcSrcBr, int regWe, bit memToReg,
                                 int rdCyc, int wrCyc, bit srcImm, logic [1:0] op, int lat);
    exp_t e;
    e.isTrap    = isTrap;
    e.busErr    = busErr;
    e.pcSrcBr   = pcSrcBr;
    e.regWeCyc  = regWe;
    e.memToReg  = memToReg;
    e.memRdCyc  = rdCyc;
    e.memWrCyc  = wrCyc;
    e.irWeCyc   = 1;
    e.aluSrcImm = srcImm;
    e.aluOp     = op;
    e.latency   = lat;
    return e;
  endfunction

  // Monitor: counts strobe cycles since the last retire/trap and scores each event against the queue
  initial begin : monitor
    int cyc, rdCyc, wrCyc, weCyc, irCyc;
    bit srcImm, prevTrap, retire, trapRise;
    logic [1:0] op;
    exp_t e;
    string nm;
    cyc = 0; rdCyc = 0; wrCyc = 0; weCyc = 0; irCyc = 0;
    srcImm = 0; prevTrap = 0; op = 2'b00;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        cyc = 0; rdCyc = 0; wrCyc = 0; weCyc = 0; irCyc = 0;
        srcImm = 0; op = 2'b00; prevTrap = 0;
        continue;
      end
      cyc++;
      if (bus.mem_rd) rdCyc++;
      if (bus.mem_wr) wrCyc++;
      if (bus.reg_we) weCyc++;
      if (bus.ir_we)  irCyc++;
      if (bus.state == 3'd2) begin
        srcImm = bus.alu_src_imm;
        op     = bus.alu_op;
      end
      retire   = bus.pc_we;
      trapRise = bus.trap && !prevTrap;
      prevTrap = bus.trap;
      if (retire || trapRise) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected event: got state %0d, expected no event", bus.state);
        end else begin
          e  = expQ.pop_front();
          nm = nameQ.pop_front();
          checkOutput({nm, " trap"},      trapRise,       e.isTrap);
          checkOutput({nm, " bus_err"},   bus.bus_err,    e.busErr);
          checkOutput({nm, " pc_src_br"}, bus.pc_src_br,  e.pcSrcBr);
          checkOutput({nm, " mem_to_reg"},bus.mem_to_reg, e.memToReg);
          checkOutput({nm, " reg_we cyc"},weCyc,          e.regWeCyc);
          checkOutput({nm, " mem_rd cyc"},rdCyc,          e.memRdCyc);
          checkOutput({nm, " mem_wr cyc"},wrCyc,          e.memWrCyc);
          checkOutput({nm, " ir_we cyc"}, irCyc,          e.irWeCyc);
          checkOutput({nm, " alu_src_imm"}, srcImm,       e.aluSrcImm);
          checkOutput({nm, " alu_op"},    op,             e.aluOp);
          checkOutput({nm, " latency"},   cyc,            e.latency);
        end
        cyc = 0; rdCyc = 0; wrCyc = 0; weCyc = 0; irCyc = 0;
        srcImm = 0; op = 2'b00;
      end
    end
  end

  // Drives one instruction until it retires or traps; returns at the start of the following cycle
  task automatic applyStimulus(input string name, input logic [31:0] instr, input logic z,
                               input int fetchWaits, input int memWaits, input exp_t e);
    int  fCnt;
    int  mCnt;
    bit  done;
    fCnt = 0; mCnt = 0; done = 0;
    expQ.push_back(e);
    nameQ.push_back(name);
    if (!e.isTrap) expRetired++;
    bus.inst_code = instr;
    bus.zero      = z;
    for (int c = 0; c < 100 && !done; c++) begin
      bus.imem_ready = (bus.state != 3'd0) || (fCnt == fetchWaits);
      bus.dmem_ready = (bus.state == 3'd3) && (mCnt == memWaits);
      if (bus.state == 3'd0) fCnt++;
      if (bus.state == 3'd3) mCnt++;
      #2;
      done = bus.pc_we || bus.trap;
      @(negedge clk);
    end
    bus.dmem_ready = 1'b0;
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout: got no retire/trap, expected one within 100 cycles", name);
    end
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    #2;
    checkOutput("reset state",    bus.state,    3'd0);
    checkOutput("reset imem_req", bus.imem_req, 1'b1);
    checkOutput("reset trap",     bus.trap,     1'b0);
    checkOutput("reset bus_err",  bus.bus_err,  1'b0);
    checkOutput("reset strobes",
                {bus.ir_we, bus.pc_we, bus.pc_src_br, bus.alu_src_imm, bus.alu_op,
                 bus.mem_rd, bus.mem_wr, bus.reg_we, bus.mem_to_reg}, 32'h0);
    expRetired = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    bus.inst_code  = 32'h0;
    bus.zero       = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    doReset();

    applyStimulus("addi",       InstAddi, 1'b0, 0, 0,  mkExp(0,0,0,1,0, 0, 0,1,2'b10, 4));
    applyStimulus("add",        InstAdd,  1'b0, 0, 0,  mkExp(0,0,0,1,0, 0, 0,0,2'b10, 4));
    applyStimulus("beq z1",     InstBeq,  1'b1, 0, 0,  mkExp(0,0,1,0,0, 0, 0,0,2'b01, 3));
    applyStimulus("beq z0",     InstBeq,  1'b0, 0, 0,  mkExp(0,0,0,0,0, 0, 0,0,2'b01, 3));
    applyStimulus("bne z1",     InstBne,  1'b1, 0, 0,  mkExp(0,0,0,0,0, 0, 0,0,2'b01, 3));
    applyStimulus("bne z0",     InstBne,  1'b0, 0, 0,  mkExp(0,0,1,0,0, 0, 0,0,2'b01, 3));
    applyStimulus("lw w0",      InstLw,   1'b0, 0, 0,  mkExp(0,0,0,1,1, 1, 0,1,2'b00, 5));
    applyStimulus("lw w3",      InstLw,   1'b0, 0, 3,  mkExp(0,0,0,1,1, 4, 0,1,2'b00, 8));
    applyStimulus("sw w0",      InstSw,   1'b0, 0, 0,  mkExp(0,0,0,0,0, 0, 1,1,2'b00, 4));
    applyStimulus("sw w15",     InstSw,   1'b0, 0, 15, mkExp(0,0,0,0,0, 0,16,1,2'b00, 19));
    applyStimulus("addi fw2",   InstAddi, 1'b0, 2, 0,  mkExp(0,0,0,1,0, 0, 0,1,2'b10, 6));

`ifdef CTRL_PERF_EN
    #2;
    checkOutput("retired", bus.retired, expRetired);
`endif

    applyStimulus("lw timeout", InstLw,   1'b0, 0, -1, mkExp(1,1,0,0,0,16, 0,1,2'b00, 20));
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("trap hold state", bus.state, 3'd5);
      checkOutput("trap hold flags", {bus.trap, bus.bus_err}, 2'b11);
      checkOutput("trap hold strobes",
                  {bus.imem_req, bus.ir_we, bus.pc_we, bus.mem_rd, bus.mem_wr, bus.reg_we}, 32'h0);
      @(negedge clk);
    end
    doReset();

    applyStimulus("jal illegal", InstJal,   1'b0, 0, 0, mkExp(1,0,0,0,0, 0, 0,0,2'b00, 3));
    #2;
    checkOutput("jal bus_err", bus.bus_err, 1'b0);
    doReset();

    applyStimulus("bad funct3",  InstBadBr, 1'b0, 0, 0, mkExp(1,0,0,0,0, 0, 0,0,2'b00, 3));
    doReset();

    bus.inst_code  = InstLw;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int c = 0; c < 20 && bus.state != 3'd3; c++) @(negedge clk);
    checkOutput("abort reached MEM", bus.state, 3'd3);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort state",   bus.state, 3'd0);
    checkOutput("abort trap",    bus.trap,  1'b0);
    checkOutput("abort strobes", {bus.pc_we, bus.reg_we, bus.mem_rd, bus.mem_wr}, 32'h0);
    @(negedge clk);
    doReset();

    applyStimulus("addi after", InstAddi, 1'b0, 0, 0, mkExp(0,0,0,1,0, 0, 0,1,2'b10, 4));
`ifdef CTRL_PERF_EN
    #2;
    checkOutput("retired after reset", bus.retired, expRetired);
`endif

    repeat (2) @(negedge clk);
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
